if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipelined MIPS core.
- Owns the PC register and issues word fetches to an instruction memory with variable read latency.
- Loads the IF/ID pipeline register consumed by the decode stage.
- Honours decode-stage stall and EX/ID redirect (branch, j, jal, jr); a redirect flushes the IF/ID register and any in-flight fetch.

---
 rtl/if_pkg.sv | 25 ++
 rtl/if_hold_buf.sv | 51 +++++
 rtl/if_fetch_stage.sv | 170 +++++++++++++++++
 tb/tb_if_fetch_stage.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_pkg;

   localparam int XLEN = 32;

   localparam logic [1:0] S_REQ  = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;
   localparam logic [1:0] S_FULL = 2'd3;

   localparam logic [XLEN-1:0] DEF_RESET_PC  = 32'h0000_3000;
   localparam logic [XLEN-1:0] DEF_NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic            vld;
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
   } ifid_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry {instr, pc} skid register; parks a fetched word while decode stalls.
module if_hold_buf
   import if_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic            load,
   input  logic            drain,
   input  logic            flush,
   input  logic [XLEN-1:0] in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            buf_vld,
   output logic [XLEN-1:0] buf_instr,
   output logic [XLEN-1:0] buf_pc
);

   logic            vld_q, vld_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] pc_q, pc_d;

   always_comb begin
      vld_d   = vld_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      if (flush || drain) begin
         vld_d = 1'b0;
      end
      if (load) begin
         vld_d   = 1'b1;
         instr_d = in_instr;
         pc_d    = in_pc;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         vld_q   <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
      end else begin
         vld_q   <= vld_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   assign buf_vld   = vld_q;
   assign buf_instr = instr_q;
   assign buf_pc    = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS fetch stage: PC, single-outstanding imem fetch, IF/ID register with stall and redirect flush.
// Define IF_PERF_CNT_EN to add the perf_fetched / perf_bubbles counters.
module if_fetch_stage
   import if_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = DEF_RESET_PC,
   parameter logic [XLEN-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic            clock,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            imem_rvalid,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   output logic [XLEN-1:0] id_instr,
   output logic [XLEN-1:0] id_pc,
`ifdef IF_PERF_CNT_EN
   output logic [XLEN-1:0] perf_fetched,
   output logic [XLEN-1:0] perf_bubbles,
`endif
   output logic [XLEN-1:0] id_pc4
);

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   ifid_t           ifid_q, ifid_d;

   logic            req;
   logic [XLEN-1:0] addr;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] tgt;
   logic            buf_load, buf_drain, buf_flush;
   logic            buf_vld;
   logic [XLEN-1:0] buf_instr, buf_pc;
   logic            word_load;

   if_hold_buf u_hold_buf (
      .clock     (clock),
      .reset     (reset),
      .load      (buf_load),
      .drain     (buf_drain),
      .flush     (buf_flush),
      .in_instr  (imem_rdata),
      .in_pc     (pc_q),
      .buf_vld   (buf_vld),
      .buf_instr (buf_instr),
      .buf_pc    (buf_pc)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ifid_d    = ifid_q;
      req       = 1'b0;
      addr      = pc_q;
      buf_load  = 1'b0;
      buf_drain = 1'b0;
      buf_flush = 1'b0;
      word_load = 1'b0;
      pc_plus4  = pc_q + XLEN'(4);
      tgt       = word_align(redirect_pc);

      // Decode consumed the current entry and nothing new arrives: bubble.
      if (!stall) begin
         ifid_d.vld = 1'b0;
      end

      case (state_q)
         S_REQ: begin
            if (redirect_valid) begin
               pc_d = tgt;
            end else begin
               req     = 1'b1;
               addr    = pc_q;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               pc_d    = tgt;
               state_d = imem_rvalid ? S_REQ : S_DROP;
            end else if (imem_rvalid) begin
               pc_d = pc_plus4;
               if (!stall) begin
                  ifid_d    = '{vld: 1'b1, instr: imem_rdata, pc: pc_q, pc4: pc_plus4};
                  word_load = 1'b1;
                  req       = 1'b1;
                  addr      = pc_plus4;
               end else begin
                  buf_load = 1'b1;
                  state_d  = S_FULL;
               end
            end
         end
         S_DROP: begin
            if (redirect_valid) begin
               pc_d = tgt;
            end
            if (imem_rvalid) begin
               state_d = S_REQ;
            end
         end
         S_FULL: begin
            if (redirect_valid) begin
               buf_flush = 1'b1;
               pc_d      = tgt;
               state_d   = S_REQ;
            end else if (!stall && buf_vld) begin
               ifid_d    = '{vld: 1'b1, instr: buf_instr, pc: buf_pc, pc4: buf_pc + XLEN'(4)};
               word_load = 1'b1;
               buf_drain = 1'b1;
               state_d   = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase

      // A redirect kills IF/ID even when decode is stalled.
      if (redirect_valid) begin
         ifid_d.vld = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         ifid_q  <= '{vld: 1'b0, instr: NOP_INSTR, pc: '0, pc4: XLEN'(4)};
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ifid_q  <= ifid_d;
      end
   end

   assign imem_req  = req && !reset;
   assign imem_addr = addr;
   assign id_valid  = ifid_q.vld;
   assign id_instr  = ifid_q.vld ? ifid_q.instr : NOP_INSTR;
   assign id_pc     = ifid_q.pc;
   assign id_pc4    = ifid_q.pc4;

`ifdef IF_PERF_CNT_EN
   logic [XLEN-1:0] fetched_q, fetched_d;
   logic [XLEN-1:0] bubbles_q, bubbles_d;

   always_comb begin
      fetched_d = fetched_q + XLEN'(word_load);
      bubbles_d = bubbles_q + XLEN'(!stall && !ifid_d.vld);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         fetched_q <= '0;
         bubbles_q <= '0;
      end else begin
         fetched_q <= fetched_d;
         bubbles_q <= bubbles_d;
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_bubbles = bubbles_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a variable-latency addr-as-data instruction memory.
module tb_if_fetch_stage;

   logic        clock;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_rvalid;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc4;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_bubbles;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int mem_lat = 1;

   if_fetch_stage dut (
      .clock          (clock),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .imem_rvalid    (imem_rvalid),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
`ifdef IF_PERF_CNT_EN
      .perf_fetched   (perf_fetched),
      .perf_bubbles   (perf_bubbles),
`endif
      .id_pc4         (id_pc4)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1, "timeout");
   end

   // Memory: returns the request address as data, mem_lat cycles after the request cycle.
   initial begin
      logic        req_seen;
      logic [31:0] addr_seen;
      logic        pending;
      int          rem;
      logic [31:0] paddr;
      pending     = 1'b0;
      rem         = 0;
      paddr       = '0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      forever begin
         @(negedge clock);
         req_seen  = imem_req;
         addr_seen = imem_addr;
         @(posedge clock);
         #1;
         imem_rvalid = 1'b0;
         if (req_seen) begin
            pending = 1'b1;
            rem     = mem_lat;
            paddr   = addr_seen;
         end
         if (pending) begin
            rem = rem - 1;
            if (rem == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = paddr;
               pending     = 1'b0;
            end
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      @(negedge clock);
   endtask

   task automatic do_reset(input int lat);
      next_cycle();
      reset          = 1'b1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      mem_lat        = lat;
      repeat (4) next_cycle();
      reset = 1'b0;
   endtask

   initial begin
      logic exp_vld;
      reset          = 1'b1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      // Reset state
      next_cycle();
      settle();
      check_eq("rst_req",   32'(imem_req), 32'd0);
      check_eq("rst_vld",   32'(id_valid), 32'd0);
      check_eq("rst_instr", id_instr, 32'h0000_0000);
      check_eq("rst_pc",    id_pc,    32'h0000_0000);
      check_eq("rst_pc4",   id_pc4,   32'h0000_0004);

      // Free-run, 1-cycle memory
      next_cycle();
      reset = 1'b0;
      settle();
      check_eq("c1_req",  32'(imem_req), 32'd1);
      check_eq("c1_addr", imem_addr, 32'h0000_3000);
      check_eq("c1_vld",  32'(id_valid), 32'd0);
      next_cycle();
      settle();
      check_eq("c2_addr", imem_addr, 32'h0000_3004);
      check_eq("c2_vld",  32'(id_valid), 32'd0);
      for (int k = 3; k <= 5; k++) begin
         next_cycle();
         settle();
         check_eq("run_vld",   32'(id_valid), 32'd1);
         check_eq("run_pc",    id_pc,    32'h3000 + 32'(4 * (k - 3)));
         check_eq("run_instr", id_instr, 32'h3000 + 32'(4 * (k - 3)));
         check_eq("run_pc4",   id_pc4,   32'h3004 + 32'(4 * (k - 3)));
      end

      // 3-cycle memory
      do_reset(3);
      for (int k = 1; k <= 11; k++) begin
         if (k > 1) next_cycle();
         settle();
         exp_vld = (k >= 5) && ((k - 5) % 3 == 0);
         check_eq("lat3_vld", 32'(id_valid), 32'(exp_vld));
         if (exp_vld) begin
            check_eq("lat3_pc",    id_pc,    32'h3000 + 32'(4 * ((k - 5) / 3)));
            check_eq("lat3_instr", id_instr, 32'h3000 + 32'(4 * ((k - 5) / 3)));
         end
         check_eq("lat3_req", 32'(imem_req), 32'(k % 3 == 1));
         if (k % 3 == 1) begin
            check_eq("lat3_addr", imem_addr, 32'h3000 + 32'(4 * ((k - 1) / 3)));
         end
      end

      // Stall for 4 cycles while a word returns
      do_reset(1);
      next_cycle();
      next_cycle();
      stall = 1'b1;
      settle();
      check_eq("st3_req", 32'(imem_req), 32'd0);
      check_eq("st3_vld", 32'(id_valid), 32'd1);
      check_eq("st3_pc",  id_pc, 32'h0000_3000);
      for (int k = 4; k <= 6; k++) begin
         next_cycle();
         settle();
         check_eq("st_hold_req", 32'(imem_req), 32'd0);
         check_eq("st_hold_vld", 32'(id_valid), 32'd1);
         check_eq("st_hold_pc",  id_pc, 32'h0000_3000);
      end
      next_cycle();
      stall = 1'b0;
      settle();
      check_eq("st7_req", 32'(imem_req), 32'd0);
      check_eq("st7_pc",  id_pc, 32'h0000_3000);
      next_cycle();
      settle();
      check_eq("st8_vld",   32'(id_valid), 32'd1);
      check_eq("st8_pc",    id_pc, 32'h0000_3004);
      check_eq("st8_instr", id_instr, 32'h0000_3004);
      check_eq("st8_req",   32'(imem_req), 32'd1);
      check_eq("st8_addr",  imem_addr, 32'h0000_3008);
      next_cycle();
      settle();
      check_eq("st9_vld", 32'(id_valid), 32'd0);
      next_cycle();
      settle();
      check_eq("st10_vld", 32'(id_valid), 32'd1);
      check_eq("st10_pc",  id_pc, 32'h0000_3008);

      // Redirect while a fetch is outstanding
      do_reset(3);
      repeat (3) next_cycle();
      next_cycle();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_4002;
      settle();
      check_eq("rd5_vld", 32'(id_valid), 32'd1);
      check_eq("rd5_pc",  id_pc, 32'h0000_3000);
      next_cycle();
      redirect_valid = 1'b0;
      settle();
      check_eq("rd6_vld", 32'(id_valid), 32'd0);
      check_eq("rd6_req", 32'(imem_req), 32'd0);
      next_cycle();
      settle();
      check_eq("rd7_vld", 32'(id_valid), 32'd0);
      check_eq("rd7_req", 32'(imem_req), 32'd0);
      next_cycle();
      settle();
      check_eq("rd8_req",  32'(imem_req), 32'd1);
      check_eq("rd8_addr", imem_addr, 32'h0000_4000);
      for (int k = 9; k <= 11; k++) begin
         next_cycle();
         settle();
         check_eq("rd_wait_vld", 32'(id_valid), 32'd0);
      end
      next_cycle();
      settle();
      check_eq("rd12_vld",   32'(id_valid), 32'd1);
      check_eq("rd12_pc",    id_pc, 32'h0000_4000);
      check_eq("rd12_instr", id_instr, 32'h0000_4000);
      check_eq("rd12_pc4",   id_pc4, 32'h0000_4004);

      // Redirect together with stall while the hold buffer is full
      do_reset(1);
      next_cycle();
      next_cycle();
      stall = 1'b1;
      next_cycle();
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_5000;
      settle();
      check_eq("rs4_vld", 32'(id_valid), 32'd1);
      check_eq("rs4_req", 32'(imem_req), 32'd0);
      next_cycle();
      redirect_valid = 1'b0;
      stall          = 1'b0;
      settle();
      check_eq("rs5_vld",   32'(id_valid), 32'd0);
      check_eq("rs5_instr", id_instr, 32'h0000_0000);
      check_eq("rs5_req",   32'(imem_req), 32'd1);
      check_eq("rs5_addr",  imem_addr, 32'h0000_5000);
      next_cycle();
      settle();
      check_eq("rs6_vld", 32'(id_valid), 32'd0);
      next_cycle();
      settle();
      check_eq("rs7_vld", 32'(id_valid), 32'd1);
      check_eq("rs7_pc",  id_pc, 32'h0000_5000);
      next_cycle();
      settle();
      check_eq("rs8_pc", id_pc, 32'h0000_5004);

      // PC wrap at the top of the address space
      do_reset(1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      settle();
      check_eq("wr1_req", 32'(imem_req), 32'd0);
      next_cycle();
      redirect_valid = 1'b0;
      settle();
      check_eq("wr2_req",  32'(imem_req), 32'd1);
      check_eq("wr2_addr", imem_addr, 32'hFFFF_FFFC);
      next_cycle();
      settle();
      check_eq("wr3_req",  32'(imem_req), 32'd1);
      check_eq("wr3_addr", imem_addr, 32'h0000_0000);
      next_cycle();
      settle();
      check_eq("wr4_vld", 32'(id_valid), 32'd1);
      check_eq("wr4_pc",  id_pc, 32'hFFFF_FFFC);
      check_eq("wr4_pc4", id_pc4, 32'h0000_0000);
`ifdef IF_PERF_CNT_EN
      check_eq("perf_fetched", perf_fetched, 32'd1);
      check_eq("perf_bubbles", perf_bubbles, 32'd2);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
